pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage core.
- Drives the stall[5:0] and flush[5:0] vectors consumed by the PC register and every pipeline register (if_id, id_ex, ex_mem, mem_wb).
- Arbitrates ID load-use requests, multi-cycle EX ops, MEM handshakes with timeout, EX branch redirects and MEM exceptions.
- Issues the PC redirect.

Parameters:
PC_W, 12, program counter width
TRAP_PC, 12'h004, redirect target on exception or MEM timeout
MEM_TIMEOUT, 16, consecutive un-acked MEM cycles before timeout trap (>=2)
CNT_W, 5, width of EX multi-cycle length/counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stallreq_id  in  1  load-use hazard detected in ID
ex_mc_start  in  1  multi-cycle op present in EX this cycle
ex_mc_len  in  CNT_W  total EX cycles of that op
branch_taken  in  1  EX resolved a taken branch/jump
branch_target  in  PC_W  EX branch target
mem_req  in  1  MEM stage has an outstanding data access
mem_ack  in  1  data memory completes access this cycle
exc_i  in  1  exception raised by instruction in MEM
stall  out  6  stage-stall vector (combinational)
flush  out  6  register-clear vector (combinational)
redirect_valid  out  1  load redirect_pc into PC this cycle
redirect_pc  out  PC_W  new PC
mem_timeout  out  1  one-cycle pulse on MEM timeout

Behaviour:
Vector encoding:
- stall[k]=1 means stage k holds (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB).
- A pipeline register after stage k inserts a bubble when stall[k]=1 and stall[k+1]=0.
- flush[k]=1 clears the register after stage k (1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb).
- flush[0] and stall[5] are always 0.
- Legal stall patterns only: 000000, 000111 (load-use), 001111 (EX multi-cycle), 011111 (MEM wait).

Reset:
- state=RUN; counters=0.
- Outputs during the rst cycle: stall=0, flush=0, redirect_valid=0, redirect_pc=0, mem_timeout=0.
- Reset mid-operation abandons any wait immediately.

FSM states: RUN, MC_WAIT, MEM_WAIT.

Per-cycle priority, highest first:
1. exc_i
   - flush=011110, stall=0, redirect_valid=1, redirect_pc=TRAP_PC, next=RUN.
   - Cancels MC_WAIT/MEM_WAIT and clears the counters.
2. MEM wait (mem_req & !mem_ack)
   - stall=011111.
   - RUN->MEM_WAIT with tcnt=1.
   - In MEM_WAIT, tcnt increments each un-acked cycle.
   - When tcnt reaches MEM_TIMEOUT-1 and still no ack:
     - That cycle: mem_timeout=1, flush=011110, stall=0, redirect to TRAP_PC.
     - next=RUN.
   - mem_ack (or mem_req low) in MEM_WAIT: stall=0 that cycle, next=RUN.
3. EX multi-cycle
   - ex_mc_start in RUN with ex_mc_len>=2:
     - stall=001111 that cycle.
     - mcnt=ex_mc_len-1; next=MC_WAIT.
   - In MC_WAIT:
     - stall=001111; mcnt decrements.
     - When mcnt==1, this is the last stall cycle; next=RUN.
     - ex_mc_start is ignored (the held op re-presents it).
   - ex_mc_len of 0 or 1: no stall.
   - Total stall cycles = ex_mc_len.
4. branch_taken
   - Honoured only when stall[3]=0: flush=000110, redirect_valid=1, redirect_pc=branch_target.
   - Otherwise ignored; EX re-presents it later.
5. stallreq_id
   - stall=000111 when no higher item is active.
   - Dropped when branch_taken fires in the same cycle: the ID instruction is wrong-path and flushed, so stall=0.

Other rules:
- MEM wait pre-empts MC_WAIT: mcnt is frozen while stall=011111 and resumes afterwards.
- A MEM wait arising in MC_WAIT enters MEM_WAIT; MC_WAIT resumes when it ends.
  - Implement this with a saved mc flag, so no extra state is needed.
- redirect_valid is never asserted together with a nonzero stall.

Test Plan:
1. Reset: assert rst for 2 cycles with all requests high -> all outputs 0; state RUN after release.
2. Load-use: stallreq_id=1 for 1 cycle -> stall=000111 that cycle only, flush=0; if_id holds its instruction and id_ex gets a bubble.
3. Multi-cycle: ex_mc_start=1, ex_mc_len=4 at cycle t -> stall=001111 for cycles t..t+3, then 0; a second ex_mc_start held high during t+1..t+3 causes no extension.
4. Branch vs load-use: branch_taken=1, branch_target=12'h0A8 with stallreq_id=1 -> flush=000110, stall=0, redirect_valid=1, redirect_pc=12'h0A8; the same branch during an MC_WAIT stall is ignored.
5. MEM wait/timeout: mem_req=1 with ack after 3 cycles -> stall=011111 for 3 cycles, then 0. With MEM_TIMEOUT=16 and no ack -> 15 stall cycles, then mem_timeout=1, flush=011110, redirect_pc=12'h004 on cycle 16.
6. Exception in MC_WAIT: ex_mc_len=8, exc_i at cycle 3 -> flush=011110, redirect to TRAP_PC, stall=0 from that cycle; next ex_mc_start with len 2 gives exactly 2 stall cycles.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage core.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stallreq_id     load-use hazard detected in ID
//   ex_mc_start     multi-cycle op present in EX this cycle
//   ex_mc_len       total EX cycles of that op
//   branch_taken    EX resolved a taken branch/jump
//   branch_target   EX branch target
//   mem_req         MEM stage has an outstanding data access
//   mem_ack         data memory completes access this cycle
//   exc_i           exception raised by instruction in MEM
//   stall[5:0]      stage-hold vector (0=PC .. 5=WB), combinational
//   flush[5:0]      pipeline-register clear vector, combinational
//   redirect_valid  load redirect_pc into PC this cycle
//   redirect_pc     new PC (0 when no redirect)
//   mem_timeout     one-cycle pulse when a MEM access times out
module pipe_ctrl #(
  parameter int              PC_W        = 12,
  parameter logic [PC_W-1:0] TRAP_PC     = 12'h004,
  parameter int              MEM_TIMEOUT = 16,
  parameter int              CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_len,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             exc_i,
  output logic [5:0]       stall,
  output logic [5:0]       flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             mem_timeout
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] ST_LU  = 6'b000111;
  localparam logic [5:0] ST_MC  = 6'b001111;
  localparam logic [5:0] ST_MEM = 6'b011111;
  localparam logic [5:0] FL_TRAP = 6'b011110;
  localparam logic [5:0] FL_BR   = 6'b000110;

  typedef enum logic [1:0] {RUN, MC_WAIT, MEM_WAIT} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [CNT_W-1:0] mcnt, mcnt_n;
  logic             mc_saved, mc_saved_n;

  logic [5:0]       stall_c, flush_c;
  logic             rv_c, mto_c;
  logic [PC_W-1:0]  rpc_c;
  logic             mem_wait, in_mc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      tcnt     <= '0;
      mcnt     <= '0;
      mc_saved <= 1'b0;
    end else begin
      state    <= state_n;
      tcnt     <= tcnt_n;
      mcnt     <= mcnt_n;
      mc_saved <= mc_saved_n;
    end
  end

  always_comb begin
    stall_c    = '0;
    flush_c    = '0;
    rv_c       = 1'b0;
    rpc_c      = '0;
    mto_c      = 1'b0;
    state_n    = state;
    tcnt_n     = tcnt;
    mcnt_n     = mcnt;
    mc_saved_n = mc_saved;

    mem_wait = mem_req & ~mem_ack;
    // A MEM wait entered from MC_WAIT keeps the multi-cycle op alive via
    // mc_saved; once the wait ends the op continues exactly as in MC_WAIT.
    in_mc = (state == MC_WAIT) || ((state == MEM_WAIT) && mc_saved);

    if (exc_i) begin
      flush_c    = FL_TRAP;
      rv_c       = 1'b1;
      rpc_c      = TRAP_PC;
      state_n    = RUN;
      tcnt_n     = '0;
      mcnt_n     = '0;
      mc_saved_n = 1'b0;
    end else if (mem_wait) begin
      if ((state == MEM_WAIT) && (tcnt == TMAX)) begin
        mto_c      = 1'b1;
        flush_c    = FL_TRAP;
        rv_c       = 1'b1;
        rpc_c      = TRAP_PC;
        state_n    = RUN;
        tcnt_n     = '0;
        mcnt_n     = '0;
        mc_saved_n = 1'b0;
      end else begin
        stall_c    = ST_MEM;
        state_n    = MEM_WAIT;
        tcnt_n     = (state == MEM_WAIT) ? tcnt + 1'b1 : TW'(1);
        mc_saved_n = in_mc;
      end
    end else begin
      tcnt_n     = '0;
      mc_saved_n = 1'b0;
      if (in_mc) begin
        stall_c = ST_MC;
        if (mcnt == CNT_W'(1)) begin
          state_n = RUN;
          mcnt_n  = '0;
        end else begin
          state_n = MC_WAIT;
          mcnt_n  = mcnt - 1'b1;
        end
      end else if (ex_mc_start && (ex_mc_len >= CNT_W'(2))) begin
        stall_c = ST_MC;
        mcnt_n  = ex_mc_len - 1'b1;
        state_n = MC_WAIT;
      end else begin
        state_n = RUN;
        if (branch_taken) begin
          flush_c = FL_BR;
          rv_c    = 1'b1;
          rpc_c   = branch_target;
        end else if (stallreq_id) begin
          stall_c = ST_LU;
        end
      end
    end
  end

  assign stall          = rst ? '0 : stall_c;
  assign flush          = rst ? '0 : flush_c;
  assign redirect_valid = rst ? 1'b0 : rv_c;
  assign redirect_pc    = rst ? '0 : rpc_c;
  assign mem_timeout    = rst ? 1'b0 : mto_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int PC_W = 12;
  localparam int CNT_W = 5;
  localparam int MEM_TIMEOUT = 16;
  localparam logic [11:0] TRAP = 12'h004;

  logic             clk = 1'b0;
  logic             rst, stallreq_id, ex_mc_start, branch_taken;
  logic             mem_req, mem_ack, exc_i;
  logic [CNT_W-1:0] ex_mc_len;
  logic [PC_W-1:0]  branch_target;
  logic [5:0]       stall, flush;
  logic             redirect_valid, mem_timeout;
  logic [PC_W-1:0]  redirect_pc;

  pipe_ctrl #(.PC_W(PC_W), .TRAP_PC(TRAP), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_len(ex_mc_len), .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_req(mem_req), .mem_ack(mem_ack), .exc_i(exc_i), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, sreq, mcs, br, mreq, mack, exc;
    logic [4:0]  mclen;
    logic [11:0] bt;
    logic [5:0]  e_stall, e_flush;
    logic        e_rv, e_mto;
    logic [11:0] e_rpc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  // Reference model state: remaining multi-cycle stall cycles and the number
  // of consecutive un-acked MEM cycles seen so far.
  int m_mc_rem  = 0;
  int m_mem_cnt = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic sreq, input logic mcs,
                              input int len, input logic br, input logic [11:0] bt,
                              input logic mreq, input logic mack, input logic exc);
    vec_t v;
    v.rst = r; v.sreq = sreq; v.mcs = mcs; v.mclen = 5'(len); v.br = br; v.bt = bt;
    v.mreq = mreq; v.mack = mack; v.exc = exc;
    v.e_stall = '0; v.e_flush = '0; v.e_rv = 0; v.e_mto = 0; v.e_rpc = '0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t v, input logic [5:0] s, input logic [5:0] f,
                              input logic rv, input logic [11:0] pc, input logic mto);
    vec_t o = v;
    o.e_stall = s; o.e_flush = f; o.e_rv = rv; o.e_rpc = pc; o.e_mto = mto;
    return o;
  endfunction

  // Behavioural model: fills expected outputs from the rules and advances model state.
  task automatic model(inout vec_t v);
    v.e_stall = '0; v.e_flush = '0; v.e_rv = 0; v.e_rpc = '0; v.e_mto = 0;
    if (v.rst) begin
      m_mc_rem = 0; m_mem_cnt = 0;
    end else if (v.exc) begin
      v.e_flush = 6'b011110; v.e_rv = 1; v.e_rpc = TRAP;
      m_mc_rem = 0; m_mem_cnt = 0;
    end else if (v.mreq && !v.mack) begin
      m_mem_cnt++;
      if (m_mem_cnt == MEM_TIMEOUT) begin
        v.e_mto = 1; v.e_flush = 6'b011110; v.e_rv = 1; v.e_rpc = TRAP;
        m_mc_rem = 0; m_mem_cnt = 0;
      end else begin
        v.e_stall = 6'b011111;
      end
    end else begin
      m_mem_cnt = 0;
      if (m_mc_rem > 0) begin
        v.e_stall = 6'b001111; m_mc_rem--;
      end else if (v.mcs && v.mclen >= 2) begin
        v.e_stall = 6'b001111; m_mc_rem = int'(v.mclen) - 1;
      end else if (v.br) begin
        v.e_flush = 6'b000110; v.e_rv = 1; v.e_rpc = v.bt;
      end else if (v.sreq) begin
        v.e_stall = 6'b000111;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; stallreq_id = v.sreq; ex_mc_start = v.mcs; ex_mc_len = v.mclen;
    branch_taken = v.br; branch_target = v.bt; mem_req = v.mreq; mem_ack = v.mack;
    exc_i = v.exc;
    #2;
    chk({tag, ".stall"}, int'(stall), int'(v.e_stall));
    chk({tag, ".flush"}, int'(flush), int'(v.e_flush));
    chk({tag, ".rv"},    int'(redirect_valid), int'(v.e_rv));
    chk({tag, ".mto"},   int'(mem_timeout), int'(v.e_mto));
    if (v.e_rv || v.rst) chk({tag, ".rpc"}, int'(redirect_pc), int'(v.e_rpc));
  endtask

  localparam logic [5:0] S0 = 6'b000000, SLU = 6'b000111, SMC = 6'b001111, SMEM = 6'b011111;
  localparam logic [5:0] FTRAP = 6'b011110, FBR = 6'b000110;

  initial begin
    vec_t v;
    rst = 1; stallreq_id = 0; ex_mc_start = 0; ex_mc_len = '0; branch_taken = 0;
    branch_target = '0; mem_req = 0; mem_ack = 0; exc_i = 0;

    // Directed per-cycle table (sequence-dependent, applied in order).
    tbl.push_back(ex(mk(1,1,1,4,1,12'hFFF,1,0,1), S0,S0,0,12'h000,0));
    tbl.push_back(ex(mk(1,1,1,4,1,12'hFFF,1,0,1), S0,S0,0,12'h000,0));
    tbl.push_back(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0));
    // load-use
    tbl.push_back(ex(mk(0,1,0,0,0,0,0,0,0), SLU,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0));
    // multi-cycle len 4, start re-presented during the hold
    for (int i = 0; i < 4; i++)
      tbl.push_back(ex(mk(0,0,1,4,0,0,0,0,0), SMC,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0));
    // len 0 / 1: no stall
    tbl.push_back(ex(mk(0,0,1,1,0,0,0,0,0), S0,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,1,0,0,0,0,0,0), S0,S0,0,0,0));
    // branch beats load-use
    tbl.push_back(ex(mk(0,1,0,0,1,12'h0A8,0,0,0), S0,FBR,1,12'h0A8,0));
    // branch ignored during MC stall, honoured afterwards
    tbl.push_back(ex(mk(0,0,1,3,1,12'h0A8,0,0,0), SMC,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,1,3,1,12'h0A8,0,0,0), SMC,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,1,3,1,12'h0A8,0,0,0), SMC,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,0,0,1,12'h0A8,0,0,0), S0,FBR,1,12'h0A8,0));
    // MEM wait acked after 3 cycles
    for (int i = 0; i < 3; i++)
      tbl.push_back(ex(mk(0,0,0,0,0,0,1,0,0), SMEM,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,0,0,0,0,1,1,0), S0,S0,0,0,0));
    // MEM wait pre-empts MC_WAIT, MC resumes with frozen count
    tbl.push_back(ex(mk(0,0,1,3,0,0,0,0,0), SMC,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,1,3,0,0,1,0,0), SMEM,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,1,3,0,0,1,1,0), SMC,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,1,3,0,0,0,0,0), SMC,S0,0,0,0));
    tbl.push_back(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0));
    // exception beats MEM wait and branch
    tbl.push_back(ex(mk(0,1,0,0,1,12'h0A8,1,0,1), S0,FTRAP,1,TRAP,0));
    tbl.push_back(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // MEM timeout: 15 stall cycles, trap on the 16th
    for (int i = 0; i < MEM_TIMEOUT - 1; i++)
      apply(ex(mk(0,0,0,0,0,0,1,0,0), SMEM,S0,0,0,0), $sformatf("tmo_wait%0d", i));
    apply(ex(mk(0,0,0,0,0,0,1,0,0), S0,FTRAP,1,TRAP,1), "tmo_trap");
    apply(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0), "tmo_after");

    // Exception during MC_WAIT (len 8, exception on cycle 3), then len-2 op
    apply(ex(mk(0,0,1,8,0,0,0,0,0), SMC,S0,0,0,0), "exc_mc1");
    apply(ex(mk(0,0,1,8,0,0,0,0,0), SMC,S0,0,0,0), "exc_mc2");
    apply(ex(mk(0,0,1,8,0,0,0,0,1), S0,FTRAP,1,TRAP,0), "exc_mc3");
    apply(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0), "exc_mc4");
    apply(ex(mk(0,0,1,2,0,0,0,0,0), SMC,S0,0,0,0), "exc_len2a");
    apply(ex(mk(0,0,1,2,0,0,0,0,0), SMC,S0,0,0,0), "exc_len2b");
    apply(ex(mk(0,0,0,0,0,0,0,0,0), S0,S0,0,0,0), "exc_len2c");

    // Randomized phase against the behavioural model
    v = mk(1,0,0,0,0,0,0,0,0);
    model(v);
    apply(v, "rnd_rst");
    for (int c = 0; c < 4000; c++) begin
      bit slow;
      slow = ((c / 80) % 3) == 1;
      v = mk($urandom_range(0,199) == 0,
             $urandom_range(0,3) == 0,
             $urandom_range(0,6) == 0,
             $urandom_range(0,9),
             $urandom_range(0,4) == 0,
             12'($urandom),
             slow ? 1'b1 : ($urandom_range(0,3) == 0),
             slow ? ($urandom_range(0,40) == 0) : ($urandom_range(0,2) == 0),
             $urandom_range(0,49) == 0);
      model(v);
      apply(v, $sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
